cv32e40p_recovery_seq: RTL

Recovery sequencer that sits directly upstream of the cv32e40p core wrapper's fault-tolerance ports. When recovery is requested, it holds the core in setback and streams a checkpointed register file from a backup RF into the core's recovery write ports, two registers per cycle. It then asserts PC/CSR recovery for one cycle and reports completion to the system fault manager.

---
 rtl/cv32e40p_pkg.sv | 17 +
 rtl/cv32e40p_recovery_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p recovery sequencer.
package cv32e40p_pkg;

  localparam int RF_AW  = 6;   // register file address width (covers FP regs)
  localparam int XLEN   = 32;
  localparam int PAIR_W = 5;   // pair counter width: up to 32 pairs

  typedef enum logic [2:0] {
    IDLE,
    SETBACK,
    RF_RD,
    RF_DRAIN,
    PC_RESTORE,
    DONE
  } recovery_state_e;

endpackage

// File: rtl/cv32e40p_recovery_seq.sv
// Recovery sequencer: holds the core in setback, streams the backup RF into
// the core's recovery write ports two registers per cycle, then triggers
// PC/CSR recovery and reports completion.
module cv32e40p_recovery_seq
  import cv32e40p_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int SETBACK_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             setback_o,
  output logic [RF_AW-1:0] bkp_raddr_a_o,
  output logic [RF_AW-1:0] bkp_raddr_b_o,
  input  logic [XLEN-1:0]  bkp_rdata_a_i,
  input  logic [XLEN-1:0]  bkp_rdata_b_i,
  output logic             recover_o,
  output logic             rf_we_a_o,
  output logic             rf_we_b_o,
  output logic [RF_AW-1:0] rf_waddr_a_o,
  output logic [RF_AW-1:0] rf_waddr_b_o,
  output logic [XLEN-1:0]  rf_wdata_a_o,
  output logic [XLEN-1:0]  rf_wdata_b_o,
  output logic             pc_recover_o
);

  localparam int NUM_PAIRS = NUM_REGS / 2;
  localparam int SB_W      = (SETBACK_CYCLES > 1) ? $clog2(SETBACK_CYCLES) : 1;

  recovery_state_e     state, state_nxt;
  logic [PAIR_W-1:0]   pair_cnt;
  logic [SB_W-1:0]     sb_cnt;
  logic                last_pair;
  logic                sb_last;

  assign last_pair = (pair_cnt == PAIR_W'(NUM_PAIRS - 1));
  assign sb_last   = (sb_cnt == SB_W'(SETBACK_CYCLES - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; start_i is only looked at in IDLE, or in DONE so a
  // request still pending at the end chains straight into a new sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start_i)   state_nxt = SETBACK;
      SETBACK:    if (sb_last)   state_nxt = RF_RD;
      RF_RD:      if (last_pair) state_nxt = RF_DRAIN;
      RF_DRAIN:                  state_nxt = PC_RESTORE;
      PC_RESTORE:                state_nxt = DONE;
      DONE:       state_nxt = start_i ? SETBACK : IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // State-decoded control outputs; read addresses only driven while reading
  always_comb begin
    busy_o        = (state != IDLE);
    setback_o     = (state == SETBACK);
    recover_o     = ((state == SETBACK) && sb_last) || (state == RF_RD) ||
                    (state == RF_DRAIN);
    pc_recover_o  = (state == PC_RESTORE);
    done_o        = (state == DONE);
    bkp_raddr_a_o = '0;
    bkp_raddr_b_o = '0;
    if (state == RF_RD) begin
      bkp_raddr_a_o = {pair_cnt, 1'b0};
      bkp_raddr_b_o = {pair_cnt, 1'b1};
    end
  end

  // Pair and setback counters; both rest at zero outside their state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pair_cnt <= '0;
      sb_cnt   <= '0;
    end else begin
      pair_cnt <= (state == RF_RD) ? pair_cnt + PAIR_W'(1) : '0;
      sb_cnt   <= ((state == SETBACK) && !sb_last) ? sb_cnt + SB_W'(1) : '0;
    end
  end

  // Write stage: one cycle behind the read; x0 is never written
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_a_o    <= 1'b0;
      rf_we_b_o    <= 1'b0;
      rf_waddr_a_o <= '0;
      rf_waddr_b_o <= '0;
      rf_wdata_a_o <= '0;
      rf_wdata_b_o <= '0;
    end else if (state == RF_RD) begin
      rf_we_a_o    <= (bkp_raddr_a_o != '0);
      rf_we_b_o    <= 1'b1;
      rf_waddr_a_o <= bkp_raddr_a_o;
      rf_waddr_b_o <= bkp_raddr_b_o;
      rf_wdata_a_o <= bkp_rdata_a_i;
      rf_wdata_b_o <= bkp_rdata_b_i;
    end else begin
      rf_we_a_o    <= 1'b0;
      rf_we_b_o    <= 1'b0;
      rf_waddr_a_o <= '0;
      rf_waddr_b_o <= '0;
      rf_wdata_a_o <= '0;
      rf_wdata_b_o <= '0;
    end
  end

endmodule
